// File: rtl/button_conditioner.sv
// Multi-channel button synchronizer + debouncer with per-channel edge strobes.
// Optional build macro COND_FALL_EDGE_EN enables the registered fall_pulse strobes.

module button_conditioner_lane #(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   accept;

  assign s      = sync_pipe[SYNC_STAGES-1];
  assign accept = (s != level) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], button};
  end

  // Any agreement with the stable level wipes progress, so bounces never accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= accept & s;
      if (s == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef COND_FALL_EDGE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fall_pulse <= 1'b0;
    else      fall_pulse <= accept & ~s;
  end
`else
  assign fall_pulse = 1'b0;
`endif

endmodule

module button_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_level
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    button_conditioner_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .button    (button[i]),
      .level     (level[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

  assign any_level = |level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: vector table plus bounce and reset sequences.
module tb_button_conditioner;
  localparam int CH = 4;

`ifdef COND_FALL_EDGE_EN
  localparam logic [CH-1:0] FALL_MASK = '1;
`else
  localparam logic [CH-1:0] FALL_MASK = '0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] button = '0;
  logic [CH-1:0] level, rise_pulse, fall_pulse;
  logic          any_level;

  int n_chk  = 0;
  int n_fail = 0;

  button_conditioner #(.CHANNELS(CH), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .button(button), .level(level),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_level(any_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] btn;
    logic [CH-1:0] lvl;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [CH-1:0] b);
    button = b;
    @(posedge clk);
    #1;
    chk("rise_and_fall_exclusive", rise_pulse & fall_pulse, 0);
  endtask

  task automatic chk_all(input string tag, input logic [CH-1:0] lvl,
                         input logic [CH-1:0] rise, input logic [CH-1:0] fall);
    chk({tag, ".level"}, level, lvl);
    chk({tag, ".rise"}, rise_pulse, rise);
    chk({tag, ".fall"}, fall_pulse, fall & FALL_MASK);
    chk({tag, ".any"}, any_level, |lvl);
  endtask

  initial begin
    logic [CH-1:0] phase_btn [3];
    logic [CH-1:0] lp, ln;
    logic [CH-1:0] bounce [8];

    // Each phase holds a new button value 8 edges; acceptance lands on edge 7.
    phase_btn[0] = 4'b0001;
    phase_btn[1] = 4'b0011;
    phase_btn[2] = 4'b0000;
    lp = '0;
    for (int p = 0; p < 3; p++) begin
      ln = phase_btn[p];
      for (int k = 1; k <= 8; k++) begin
        vec_t v;
        v.btn  = ln;
        v.lvl  = (k >= 7) ? ln : lp;
        v.rise = (k == 7) ? (ln & ~lp) : '0;
        v.fall = (k == 7) ? (lp & ~ln) : '0;
        tbl.push_back(v);
      end
      lp = ln;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", '0, '0, '0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].btn);
      chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].rise, tbl[i].fall);
    end

    // Bounce on channel 1: 1,1,0,0,1,1,0,0 then held high.
    bounce = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    foreach (bounce[i]) begin
      step(bounce[i]);
      chk_all($sformatf("bounce%0d", i), '0, '0, '0);
    end
    for (int k = 1; k <= 6; k++) begin
      step(4'b0010);
      chk_all($sformatf("bounce_hold%0d", k), '0, '0, '0);
    end
    step(4'b0010);
    chk_all("bounce_accept", 4'b0010, 4'b0010, '0);
    step(4'b0010);
    chk_all("bounce_after", 4'b0010, '0, '0);
    for (int k = 1; k <= 10; k++) step(4'b0000);
    chk_all("bounce_return", '0, '0, '0);

    // Reset asserted mid-debounce on channel 2, button kept high through release.
    for (int k = 1; k <= 5; k++) begin
      step(4'b0100);
      chk_all($sformatf("pre_rst%0d", k), '0, '0, '0);
    end
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", '0, '0, '0);
    @(posedge clk);
    #1;
    chk_all("rst_held", '0, '0, '0);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(4'b0100);
      chk_all($sformatf("post_rst%0d", k), '0, '0, '0);
    end
    step(4'b0100);
    chk_all("post_rst_accept", 4'b0100, 4'b0100, '0);
    step(4'b0100);
    chk_all("post_rst_after", 4'b0100, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
